// File: rtl/branch_predict_ctrl.sv
// Bimodal branch predictor: 2^INDEX_BITS saturating 2-bit counters with a sequential table clear.
// Optional statistics outputs (lookup_count, miss_count) are enabled by defining BP_STATS_EN.
module branch_predict_ctrl #(
  parameter int unsigned INDEX_BITS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        init,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic        outcome,
  input  logic        miss,
  output logic        prediction,
  output logic        pred_valid,
`ifdef BP_STATS_EN
  output logic [15:0] lookup_count,
  output logic [15:0] miss_count,
`endif
  output logic        busy
);

  localparam int unsigned DEPTH = 1 << INDEX_BITS;
  localparam logic [0:0] READY = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [1:0]            ctr_q [DEPTH];
  logic [0:0]            state_q, state_d;
  logic [INDEX_BITS-1:0] ptr_q, ptr_d;
  logic [INDEX_BITS-1:0] lidx, uidx;
  logic [1:0]            upd_old, upd_new, look_val;
  logic                  upd_en;

  assign lidx    = lookup_pc[INDEX_BITS+1:2];
  assign uidx    = update_pc[INDEX_BITS+1:2];
  assign upd_old = ctr_q[uidx];
  assign upd_en  = update_valid && (state_q == READY);
  assign busy    = (state_q == CLEAR);

  always_comb begin
    upd_new = upd_old;
    if (outcome) begin
      if (upd_old != 2'b11) upd_new = upd_old + 2'b01;
    end else begin
      if (upd_old != 2'b00) upd_new = upd_old - 2'b01;
    end
  end

  // Same-index update forwards its new value so the lookup sees the post-update counter.
  assign look_val = (upd_en && (uidx == lidx)) ? upd_new : ctr_q[lidx];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      READY: begin
        if (init) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        if (init) begin
          ptr_d = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == '1) state_d = READY;
        end
      end
      default: begin
        state_d = READY;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) ctr_q[i] <= 2'b01;
    end else if (state_q == CLEAR) begin
      ctr_q[ptr_q] <= 2'b01;
    end else if (update_valid) begin
      ctr_q[uidx] <= upd_new;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= READY;
      ptr_q      <= '0;
      prediction <= 1'b0;
      pred_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      pred_valid <= lookup_valid;
      prediction <= lookup_valid && (state_q == READY) && look_val[1];
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lookup_count <= '0;
      miss_count   <= '0;
    end else if (init) begin
      lookup_count <= '0;
      miss_count   <= '0;
    end else begin
      if (lookup_valid && (lookup_count != 16'hFFFF)) lookup_count <= lookup_count + 16'd1;
      if (update_valid && miss && (state_q == READY) && (miss_count != 16'hFFFF)) begin
        miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule
